// File: rtl/snake_move_ctrl_if.sv
// Signal bundle between the game logic / pixel renderer and the snake movement sequencer.
// master = game side (drives requests, renderer index); slave = sequencer.
interface snake_move_ctrl_if #(
    parameter int LEN_W = 5
);
    logic             tick;
    logic             init;
    logic             pause;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             food_valid;
    logic [12:0]      food_pos;
    logic [LEN_W-1:0] rd_idx;
    logic [12:0]      rd_pos;
    logic             rd_valid;
    logic [LEN_W-1:0] length;
    logic [12:0]      head_pos;
    logic             busy;
    logic             died;
    logic             ate;
    logic             dead;

    modport master (
        output tick, init, pause, key_valid, key_code, food_valid, food_pos, rd_idx,
        input  rd_pos, rd_valid, length, head_pos, busy, died, ate, dead
    );

    modport slave (
        input  tick, init, pause, key_valid, key_code, food_valid, food_pos, rd_idx,
        output rd_pos, rd_valid, length, head_pos, busy, died, ate, dead
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake movement/collision sequencer: owns the segment store and steps the snake one
// segment per cycle (head, wall check, self scan, growth, body shift) on each accepted tick.
module snake_move_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int INIT_LEN = 4
) (
    input logic              clk,
    input logic              rst_n,
    snake_move_ctrl_if.slave bus
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO       = LEN_W'(2);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] INIT_L    = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LOAD_LAST = LEN_W'(INIT_LEN - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_HEAD,
        S_SCAN,
        S_SHIFT,
        S_DEAD
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] idx, idx_nx, idx_m1;
    logic [LEN_W-1:0] length_r, limit, new_len;
    logic [1:0]       dir, pend_dir, key_dir;
    logic             key_hit, key_ok;

    logic [12:0]      seg [MAX_LEN];
    logic [12:0]      seg_head, scan_pos, shift_src, seg_wdata;
    logic [IDX_W-1:0] seg_widx;
    logic             seg_we, head_we;

    logic [5:0]       hy, ny;
    logic [6:0]       hx, nx;
    logic [12:0]      nh_cmb, nh_r;
    logic             off_field, grow_r;

    logic             step_go, step_done, enter_dead;
    logic             died_r, ate_r, dead_r;
    logic [12:0]      rd_pos_r;
    logic             rd_valid_r;

    assign seg_head  = seg[0];
    assign idx_m1    = idx - ONE;
    assign scan_pos  = seg[idx[IDX_W-1:0]];
    assign shift_src = seg[idx_m1[IDX_W-1:0]];
    assign hy        = seg_head[12:7];
    assign hx        = seg_head[6:0];

    // Fields wrap modulo their width; anything landing outside 64x48 is a wall hit.
    always_comb begin
        ny = hy;
        nx = hx;
        case (dir)
            DIR_UP:   ny = hy - 6'd1;
            DIR_DOWN: ny = hy + 6'd1;
            DIR_LEFT: nx = hx - 7'd1;
            default:  nx = hx + 7'd1;
        endcase
    end

    assign nh_cmb    = {ny, nx};
    assign off_field = nx[6] | (ny[5] & ny[4]);

    // The tail cell vacates during this step, so it is exempt unless the snake grows.
    assign limit   = grow_r ? (length_r - ONE) : (length_r - TWO);
    assign new_len = (grow_r && (length_r != MAX_L)) ? (length_r + ONE) : length_r;

    always_comb begin
        key_hit = 1'b1;
        key_dir = DIR_RIGHT;
        case (bus.key_code)
            8'h75:   key_dir = DIR_UP;
            8'h72:   key_dir = DIR_DOWN;
            8'h6B:   key_dir = DIR_LEFT;
            8'h74:   key_dir = DIR_RIGHT;
            default: key_hit = 1'b0;
        endcase
    end

    // Bit 1 of the direction code separates the vertical pair from the horizontal pair.
    assign key_ok = bus.key_valid & key_hit & (key_dir[1] != dir[1]) &
                    (state != S_LOAD) & (state != S_DEAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        seg_we     = 1'b0;
        seg_widx   = idx[IDX_W-1:0];
        seg_wdata  = '0;
        head_we    = 1'b0;
        step_go    = 1'b0;
        step_done  = 1'b0;
        enter_dead = 1'b0;

        case (state)
            S_LOAD: begin
                seg_we    = 1'b1;
                seg_wdata = {6'd0, 7'(LOAD_LAST - idx)};
                if (idx == LOAD_LAST) begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + ONE;
                end
            end
            S_IDLE: begin
                if (bus.tick && !bus.pause) begin
                    step_go  = 1'b1;
                    state_nx = S_HEAD;
                end
            end
            S_HEAD: begin
                if (off_field) begin
                    enter_dead = 1'b1;
                    state_nx   = S_DEAD;
                end else begin
                    state_nx = S_SCAN;
                    idx_nx   = '0;
                end
            end
            S_SCAN: begin
                if (scan_pos == nh_r) begin
                    enter_dead = 1'b1;
                    state_nx   = S_DEAD;
                end else if (idx == limit) begin
                    state_nx = S_SHIFT;
                    idx_nx   = new_len - ONE;
                end else begin
                    idx_nx = idx + ONE;
                end
            end
            S_SHIFT: begin
                if (idx != '0) begin
                    seg_we    = 1'b1;
                    seg_wdata = shift_src;
                end
                // The last body move and the new head share one edge.
                if (idx > ONE) begin
                    idx_nx = idx - ONE;
                end else begin
                    head_we   = 1'b1;
                    step_done = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            S_DEAD: state_nx = S_DEAD;
            default: state_nx = S_LOAD;
        endcase

        if (bus.init) begin
            state_nx   = S_LOAD;
            idx_nx     = '0;
            seg_we     = 1'b0;
            head_we    = 1'b0;
            step_go    = 1'b0;
            step_done  = 1'b0;
            enter_dead = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (seg_we) begin
            seg[seg_widx] <= seg_wdata;
        end
        if (head_we) begin
            seg[0] <= nh_r;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_HEAD) begin
            nh_r   <= nh_cmb;
            grow_r <= bus.food_valid & (nh_cmb == bus.food_pos);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length_r <= INIT_L;
            dir      <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            died_r   <= 1'b0;
            ate_r    <= 1'b0;
            dead_r   <= 1'b0;
        end else begin
            died_r <= enter_dead;
            ate_r  <= step_done & grow_r;
            if (bus.init) begin
                length_r <= INIT_L;
                dir      <= DIR_RIGHT;
                pend_dir <= DIR_RIGHT;
                dead_r   <= 1'b0;
            end else begin
                if (enter_dead) begin
                    dead_r <= 1'b1;
                end
                if (step_go) begin
                    dir <= pend_dir;
                end
                if (step_done) begin
                    length_r <= new_len;
                end
                if (key_ok) begin
                    pend_dir <= key_dir;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pos_r   <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_pos_r   <= (bus.rd_idx < MAX_L) ? seg[bus.rd_idx[IDX_W-1:0]] : '0;
            rd_valid_r <= bus.rd_idx < length_r;
        end
    end

    assign bus.rd_pos   = rd_pos_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.length   = length_r;
    assign bus.head_pos = seg_head;
    assign bus.busy     = (state != S_IDLE) && (state != S_DEAD);
    assign bus.died     = died_r;
    assign bus.ate      = ate_r;
    assign bus.dead     = dead_r;
endmodule
